// File: rtl/red_pitaya_pwm.sv
// red_pitaya_pwm -- sigma-style PWM DAC for one analog output channel.
//
// A frame is 16 PWM periods of FULL clocks each. Every period is high for
// the base duty v (cfg_i[23:16]); period k gets one extra high cycle when
// mask bit b[k] (cfg_i[15:0]) is set. The result is roughly 12 bits of
// average resolution. The configuration is latched only at the frame end,
// so a frame never mixes two settings.
//
// Ports:
//   clk_i   - clock
//   rstn_i  - asynchronous active-low reset
//   cfg_i   - conversion word {v[7:0], b[15:0]}, quasi-static in clk_i domain
//   pwm_o   - registered PWM output
//   sync_o  - registered one-cycle pulse on the first cycle of each frame
module red_pitaya_pwm #(
  parameter int FULL = 156
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [23:0] cfg_i,
  output logic        pwm_o,
  output logic        sync_o
);

  localparam logic [7:0] VMAX = 8'(FULL - 1);

  logic [7:0]  vcnt_q, vcnt_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  v_r_q, v_r_d;
  logic [15:0] b_r_q, b_r_d;
  logic        pwm_q, pwm_d;
  logic        sync_q, sync_d;

  logic        vwrap;
  logic        frame_end;
  logic [8:0]  th;

  always_comb begin
    vwrap     = (vcnt_q == VMAX);
    frame_end = vwrap && (bcnt_q == 4'd15);

    vcnt_d = vwrap ? 8'd0 : vcnt_q + 8'd1;
    // 4-bit counter wraps 15 -> 0 on its own.
    bcnt_d = vwrap ? bcnt_q + 4'd1 : bcnt_q;

    v_r_d = v_r_q;
    b_r_d = b_r_q;
    if (frame_end) begin
      v_r_d = cfg_i[23:16];
      b_r_d = cfg_i[15:0];
    end

    // 9-bit threshold: base duty plus this period's extra count. Base
    // values >= FULL keep the pin high through every period wrap.
    th     = {1'b0, v_r_q} + {8'd0, b_r_q[bcnt_q]};
    pwm_d  = ({1'b0, vcnt_q} < th);
    sync_d = (vcnt_q == 8'd0) && (bcnt_q == 4'd0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vcnt_q <= '0;
      bcnt_q <= '0;
      v_r_q  <= '0;
      b_r_q  <= '0;
      pwm_q  <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      vcnt_q <= vcnt_d;
      bcnt_q <= bcnt_d;
      v_r_q  <= v_r_d;
      b_r_q  <= b_r_d;
      pwm_q  <= pwm_d;
      sync_q <= sync_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign sync_o = sync_q;

endmodule
